// File: rtl/mp64_mtimer.sv
// mp64_mtimer: NUM_CH independent compare/match timers on the byte-wide MMIO bus.
// Define MP64_TIMER_SNAPSHOT_EN to latch the counter on COUNT byte-0 reads for coherent multi-byte reads.
module mp64_mtimer #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 32,
   parameter int AW     = $clog2(NUM_CH) + 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic [AW-1:0]     addr,
   input  logic [7:0]        wdata,
   input  logic              wen,
   output logic [7:0]        rdata,
   output logic              ack,
   output logic [NUM_CH-1:0] irq,
   output logic              irq_any
);
   localparam int NB = CNT_W / 8;

   logic [AW-1:0]    ch_sel;
   logic [3:0]       reg_sel;

   logic [CNT_W-1:0] cnt_q   [NUM_CH];
   logic [CNT_W-1:0] cnt_d   [NUM_CH];
   logic [CNT_W-1:0] cmp_q   [NUM_CH];
   logic [CNT_W-1:0] cmp_d   [NUM_CH];
   logic [3:0]       ctrl_q  [NUM_CH];
   logic [3:0]       ctrl_d  [NUM_CH];
   logic [7:0]       presc_q [NUM_CH];
   logic [7:0]       presc_d [NUM_CH];
   logic [7:0]       pcnt_q  [NUM_CH];
   logic [7:0]       pcnt_d  [NUM_CH];
   logic [NUM_CH-1:0] match_q, match_d;
   logic [NUM_CH-1:0] ovf_q, ovf_d;
`ifdef MP64_TIMER_SNAPSHOT_EN
   logic [CNT_W-1:0] shadow_q [NUM_CH];
   logic [CNT_W-1:0] shadow_d [NUM_CH];
`endif
   logic [7:0]       rdata_q, rdata_d;
   logic             ack_q;

   logic             hit, wr, en, tick, is_match, carry, set_ovf, clr_m, clr_o;
   logic [CNT_W-1:0] inc;
   logic [31:0]      cv, sv, mv;

   assign ch_sel  = addr >> 4;
   assign reg_sel = addr[3:0];

   always_comb begin
      cnt_d    = cnt_q;
      cmp_d    = cmp_q;
      ctrl_d   = ctrl_q;
      presc_d  = presc_q;
      pcnt_d   = pcnt_q;
      match_d  = match_q;
      ovf_d    = ovf_q;
`ifdef MP64_TIMER_SNAPSHOT_EN
      shadow_d = shadow_q;
`endif
      hit      = 1'b0;
      wr       = 1'b0;
      en       = 1'b0;
      tick     = 1'b0;
      is_match = 1'b0;
      carry    = 1'b0;
      inc      = '0;
      set_ovf  = 1'b0;
      clr_m    = 1'b0;
      clr_o    = 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         hit      = req && (ch_sel == AW'(i));
         wr       = hit && wen;
         en       = ctrl_q[i][0];
         tick     = en && (pcnt_q[i] == presc_q[i]);
         is_match = tick && (cnt_q[i] == cmp_q[i]) && (cmp_q[i] != '0);
         {carry, inc} = {1'b0, cnt_q[i]} + {{CNT_W{1'b0}}, 1'b1};
         pcnt_d[i] = (en && !tick) ? pcnt_q[i] + 8'd1 : 8'd0;

         if (is_match && ctrl_q[i][2]) cnt_d[i] = '0;
         else if (tick)                cnt_d[i] = inc;
         set_ovf = tick && !(is_match && ctrl_q[i][2]) && carry;
         if (is_match && ctrl_q[i][3]) ctrl_d[i][0] = 1'b0;

         // CPU byte writes are applied after the tick so they override it
         for (int unsigned j = 0; j < NB; j++) begin
            if (wr && reg_sel == 4'(j))     cnt_d[i][8*j +: 8] = wdata;
            if (wr && reg_sel == 4'(4 + j)) cmp_d[i][8*j +: 8] = wdata;
         end
         if (wr && reg_sel == 4'h8) ctrl_d[i]  = wdata[3:0];
         if (wr && reg_sel == 4'hA) presc_d[i] = wdata;

         clr_m = wr && (reg_sel == 4'h9) && wdata[0];
         clr_o = wr && (reg_sel == 4'h9) && wdata[1];
         match_d[i] = (match_q[i] && !clr_m) || is_match;
         ovf_d[i]   = (ovf_q[i] && !clr_o) || set_ovf;
`ifdef MP64_TIMER_SNAPSHOT_EN
         if (hit && !wen && reg_sel == 4'h0) shadow_d[i] = cnt_q[i];
`endif
      end
   end

   always_comb begin
      rdata_d = '0;
      cv      = '0;
      sv      = '0;
      mv      = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (req && !wen && ch_sel == AW'(i)) begin
            cv = 32'(cnt_q[i]);
            mv = 32'(cmp_q[i]);
`ifdef MP64_TIMER_SNAPSHOT_EN
            sv = 32'(shadow_q[i]);
`else
            sv = cv;
`endif
            case (reg_sel)
               4'h0:    rdata_d = cv[7:0];
               4'h1:    rdata_d = sv[15:8];
               4'h2:    rdata_d = sv[23:16];
               4'h3:    rdata_d = sv[31:24];
               4'h4:    rdata_d = mv[7:0];
               4'h5:    rdata_d = mv[15:8];
               4'h6:    rdata_d = mv[23:16];
               4'h7:    rdata_d = mv[31:24];
               4'h8:    rdata_d = {4'b0, ctrl_q[i]};
               4'h9:    rdata_d = {6'b0, ovf_q[i], match_q[i]};
               4'hA:    rdata_d = presc_q[i];
               default: rdata_d = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            cnt_q[i]    <= '0;
            cmp_q[i]    <= '0;
            ctrl_q[i]   <= '0;
            presc_q[i]  <= '0;
            pcnt_q[i]   <= '0;
`ifdef MP64_TIMER_SNAPSHOT_EN
            shadow_q[i] <= '0;
`endif
         end
         match_q <= '0;
         ovf_q   <= '0;
         rdata_q <= '0;
         ack_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         cmp_q    <= cmp_d;
         ctrl_q   <= ctrl_d;
         presc_q  <= presc_d;
         pcnt_q   <= pcnt_d;
`ifdef MP64_TIMER_SNAPSHOT_EN
         shadow_q <= shadow_d;
`endif
         match_q  <= match_d;
         ovf_q    <= ovf_d;
         rdata_q  <= rdata_d;
         ack_q    <= req;
      end
   end

   always_comb begin
      irq = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) irq[i] = match_q[i] & ctrl_q[i][1];
   end

   assign irq_any = |irq;
   assign rdata   = rdata_q;
   assign ack     = ack_q;
endmodule
